// File: rtl/pwm_pkg.sv
// Shared types and small helpers for the level-shifted PWM bank.
package pwm_pkg;

  typedef enum logic [1:0] {IDLE, DIV, LIMITS, RUN} bank_state_e;

  // Complementary gate pair {low side, high side} for a pre-dead-time level.
  function automatic logic [1:0] gatePair(input logic p);
    return {~p, p};
  endfunction

  // Counter width able to hold 0..n-1.
  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_dead_time_ch.sv
// One dead-timed complementary channel: any edge on P blanks both gates for
// DeadTime cycles before the pair follows P again.
module pwm_dead_time_ch
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = 8
) (
  input  logic                MClk,
  input  logic                Rst,
  input  logic                Run,
  input  logic                P,
  input  logic [DT_WIDTH-1:0] DeadTime,
  output logic [1:0]          Gate
);

  logic                pPrev;
  logic                wasRun;
  logic [DT_WIDTH-1:0] cnt;

  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      pPrev  <= 1'b0;
      wasRun <= 1'b0;
      cnt    <= '0;
      Gate   <= 2'b00;
    end else begin
      pPrev  <= P;
      wasRun <= Run;
      if (!Run) begin
        Gate <= 2'b00;
        cnt  <= '0;
      end else if ((P != pPrev) || !wasRun) begin
        // Entering RUN is treated like an edge so the first drive is dead-timed too.
        if (DeadTime == '0) begin
          Gate <= gatePair(P);
        end else begin
          Gate <= 2'b00;
          cnt  <= DeadTime - 1'b1;
        end
      end else if (cnt != '0) begin
        cnt  <= cnt - 1'b1;
        Gate <= 2'b00;
      end else begin
        Gate <= gatePair(P);
      end
    end
  end

endmodule

// File: rtl/pwm_level_bank.sv
// N-level level-shifted carrier PWM bank: divides full scale into bands, runs
// one triangle carrier offset into each band and dead-times each level's gate pair.
module pwm_level_bank
  import pwm_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int LEVEL_COUNT = 4,
  parameter int DT_WIDTH    = 8
) (
  input  logic                     MClk,
  input  logic                     Rst,
  input  logic                     Enable,
  input  logic [BIT_WIDTH-1:0]     PWMMaxCount,
  input  logic [BIT_WIDTH-1:0]     StepSize,
  input  logic [BIT_WIDTH-1:0]     InterleaveOffset,
  input  logic [DT_WIDTH-1:0]      DeadTimeCount,
  input  logic [BIT_WIDTH-1:0]     Compare,
  input  logic                     CompareValid,
  output logic [2*LEVEL_COUNT-1:0] S,
  output logic                     Ready,
  output logic                     CarrierSync,
  output logic                     CfgError
);

  localparam int DCW = cntWidth(BIT_WIDTH);
  localparam int LCW = cntWidth(LEVEL_COUNT);
  localparam logic [BIT_WIDTH:0]   DIVISOR   = (BIT_WIDTH+1)'(LEVEL_COUNT);
  localparam logic [BIT_WIDTH-1:0] DIVISOR_W = BIT_WIDTH'(LEVEL_COUNT);

  bank_state_e                            state;
  logic [BIT_WIDTH-1:0]                   divQuo, divRem, band, acc;
  logic [BIT_WIDTH-1:0]                   stepReg, offsetReg, triCnt, shadow, active;
  logic [DT_WIDTH-1:0]                    dtReg;
  logic [DCW-1:0]                         divCnt;
  logic [LCW-1:0]                         lvlIdx;
  logic [LEVEL_COUNT-1:0][BIT_WIDTH-1:0]  lower;
  logic                                   dirDown;
  logic [LEVEL_COUNT-1:0]                 pLvl;
  logic                                   run;

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  logic [BIT_WIDTH:0]   remShift;
  logic                 remGe;
  logic [BIT_WIDTH-1:0] remNext, quoNext;
  assign remShift = {divRem, divQuo[BIT_WIDTH-1]};
  assign remGe    = remShift >= DIVISOR;
  assign remNext  = remGe ? (remShift[BIT_WIDTH-1:0] - DIVISOR_W) : remShift[BIT_WIDTH-1:0];
  assign quoNext  = {divQuo[BIT_WIDTH-2:0], remGe};

  logic [BIT_WIDTH:0]   triSum;
  logic [BIT_WIDTH-1:0] bandTop, shadowNext;
  logic                 upHit, dnHit;
  assign triSum     = {1'b0, triCnt} + {1'b0, stepReg};
  assign bandTop    = band - 1'b1;
  assign upHit      = triSum >= {1'b0, bandTop};
  assign dnHit      = triCnt <= stepReg;
  assign shadowNext = CompareValid ? Compare : shadow;
  assign run        = (state == RUN) && Enable;

  always_ff @(posedge MClk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      divQuo      <= '0;
      divRem      <= '0;
      band        <= '0;
      acc         <= '0;
      stepReg     <= '0;
      offsetReg   <= '0;
      triCnt      <= '0;
      shadow      <= '0;
      active      <= '0;
      dtReg       <= '0;
      divCnt      <= '0;
      lvlIdx      <= '0;
      lower       <= '0;
      dirDown     <= 1'b0;
      Ready       <= 1'b0;
      CarrierSync <= 1'b0;
      CfgError    <= 1'b0;
    end else begin
      CarrierSync <= 1'b0;
      if (CompareValid) shadow <= Compare;
      if (!Enable) begin
        state    <= IDLE;
        Ready    <= 1'b0;
        CfgError <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!CfgError) begin
            divQuo    <= PWMMaxCount;
            divRem    <= '0;
            divCnt    <= '0;
            stepReg   <= StepSize;
            offsetReg <= InterleaveOffset;
            dtReg     <= DeadTimeCount;
            state     <= DIV;
          end
          DIV: begin
            divQuo <= quoNext;
            divRem <= remNext;
            divCnt <= divCnt + 1'b1;
            if (divCnt == DCW'(BIT_WIDTH-1)) begin
              if (quoNext == '0) begin
                CfgError <= 1'b1;
                state    <= IDLE;
              end else begin
                band   <= quoNext;
                acc    <= '0;
                lvlIdx <= '0;
                state  <= LIMITS;
              end
            end
          end
          LIMITS: begin
            lower[lvlIdx] <= acc;
            acc           <= acc + band;
            lvlIdx        <= lvlIdx + 1'b1;
            if (lvlIdx == LCW'(LEVEL_COUNT-1)) begin
              triCnt  <= (offsetReg > bandTop) ? bandTop : offsetReg;
              dirDown <= 1'b0;
              // First period uses the pending shadow rather than a stale value.
              active  <= shadowNext;
              state   <= RUN;
            end
          end
          RUN: begin
            Ready <= 1'b1;
            if (!dirDown) begin
              if (upHit) begin
                triCnt  <= bandTop;
                dirDown <= 1'b1;
              end else begin
                triCnt <= triSum[BIT_WIDTH-1:0];
              end
            end else if (dnHit) begin
              triCnt      <= '0;
              dirDown     <= 1'b0;
              active      <= shadowNext;
              CarrierSync <= 1'b1;
            end else begin
              triCnt <= triCnt - stepReg;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar k = 0; k < LEVEL_COUNT; k++) begin : gLvl
    logic [BIT_WIDTH:0] carrier;
    assign carrier = {1'b0, lower[k]} + {1'b0, triCnt};
    assign pLvl[k] = {1'b0, active} > carrier;

    pwm_dead_time_ch #(.DT_WIDTH(DT_WIDTH)) uCh (
      .MClk     (MClk),
      .Rst      (Rst),
      .Run      (run),
      .P        (pLvl[k]),
      .DeadTime (dtReg),
      .Gate     (S[2*k+1:2*k])
    );
  end

endmodule

// File: tb/tb_pwm_level_bank.sv
// Scoreboard bench for pwm_level_bank: per-carrier-period gate duty counts and
// Ready latency are queued by the stimulus and checked by a monitor.
module tb_pwm_level_bank;
  localparam int LC = 4;

  logic        MClk = 1'b0;
  logic        Rst = 1'b1;
  logic        Enable = 1'b0;
  logic [15:0] PWMMaxCount = '0, StepSize = '0, InterleaveOffset = '0, Compare = '0;
  logic [7:0]  DeadTimeCount = '0;
  logic        CompareValid = 1'b0;
  logic [7:0]  S;
  logic        Ready, CarrierSync, CfgError;

  pwm_level_bank #(.BIT_WIDTH(16), .LEVEL_COUNT(LC), .DT_WIDTH(8)) dut (
    .MClk(MClk), .Rst(Rst), .Enable(Enable), .PWMMaxCount(PWMMaxCount),
    .StepSize(StepSize), .InterleaveOffset(InterleaveOffset),
    .DeadTimeCount(DeadTimeCount), .Compare(Compare), .CompareValid(CompareValid),
    .S(S), .Ready(Ready), .CarrierSync(CarrierSync), .CfgError(CfgError)
  );

  always #5 MClk = ~MClk;

  int cyc = 0;
  always @(posedge MClk) cyc <= cyc + 1;

  typedef struct packed {
    logic [LC-1:0][15:0] hi;
    logic [LC-1:0][15:0] lo;
  } per_exp_t;

  per_exp_t perQ[$];
  string    tagQ[$];
  int       readyQ[$];
  int       nChecks = 0, nPass = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: accumulate gate high counts per carrier period, compare on each sync.
  int       hiCnt[LC], loCnt[LC];
  int       bothHigh = 0;
  logic     readyPrev = 1'b0;
  per_exp_t mExp;
  string    mTag;
  always @(negedge MClk) begin
    if (CarrierSync) begin
      if (perQ.size() > 0) begin
        mExp = perQ.pop_front();
        mTag = tagQ.pop_front();
        for (int k = 0; k < LC; k++) begin
          check($sformatf("%s L%0d high", mTag, k), hiCnt[k], int'(mExp.hi[k]));
          check($sformatf("%s L%0d low", mTag, k), loCnt[k], int'(mExp.lo[k]));
        end
      end
      for (int k = 0; k < LC; k++) begin hiCnt[k] = 0; loCnt[k] = 0; end
    end
    for (int k = 0; k < LC; k++) begin
      hiCnt[k] += int'(S[2*k]);
      loCnt[k] += int'(S[2*k+1]);
      if (S[2*k] && S[2*k+1]) bothHigh++;
    end
    if (Ready && !readyPrev) begin
      if (readyQ.size() > 0) check("ready latency", cyc, readyQ.pop_front());
      else check("unexpected ready", 1, 0);
    end
    readyPrev = Ready;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge MClk);
  endtask

  task automatic waitSync(input string name);
    bit seen = 0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge MClk);
      if (CarrierSync) seen = 1;
    end
    if (!seen) check({name, " sync timeout"}, 0, 1);
  endtask

  task automatic waitReady(input string name);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge MClk);
      if (Ready) seen = 1;
    end
    if (!seen) check({name, " ready timeout"}, 0, 1);
  endtask

  task automatic loadCompare(input logic [15:0] v);
    Compare = v;
    CompareValid = 1'b1;
    tick(1);
    CompareValid = 1'b0;
  endtask

  // Ready must rise 21 edges after the edge sampling Enable=1 (the next edge, cyc+1).
  task automatic startRun(input logic [15:0] maxc, input logic [7:0] dt, input string name);
    PWMMaxCount = maxc;
    DeadTimeCount = dt;
    StepSize = 16'd1;
    InterleaveOffset = 16'd0;
    Enable = 1'b1;
    readyQ.push_back(cyc + 22);
    waitReady(name);
  endtask

  task automatic pushPer(input string tag, input int h0, l0, h1, l1, h2, l2, h3, l3);
    per_exp_t e;
    tick(1);
    e.hi[0] = 16'(h0); e.lo[0] = 16'(l0);
    e.hi[1] = 16'(h1); e.lo[1] = 16'(l1);
    e.hi[2] = 16'(h2); e.lo[2] = 16'(l2);
    e.hi[3] = 16'(h3); e.lo[3] = 16'(l3);
    perQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    tick(2);
    check("reset S", int'(S), 0);
    check("reset Ready", int'(Ready), 0);
    check("reset CarrierSync", int'(CarrierSync), 0);
    check("reset CfgError", int'(CfgError), 0);
    Rst = 1'b0;
    tick(1);

    // Band=250, 498-cycle period; Compare=600 -> level 2 high while tri<100.
    loadCompare(16'd600);
    startRun(16'd1000, 8'd0, "run600");
    check("run CfgError", int'(CfgError), 0);
    waitSync("run600 first");
    pushPer("c600 dt0", 498, 0, 498, 0, 199, 299, 0, 498);
    waitSync("run600 cmp");

    // Mid-period compare change must not disturb the current period.
    pushPer("hold600", 498, 0, 498, 0, 199, 299, 0, 498);
    tick(100);
    loadCompare(16'd300);
    waitSync("hold cmp");
    waitSync("straddle");
    pushPer("c300 dt0", 498, 0, 99, 399, 0, 498, 0, 498);
    waitSync("c300 cmp");

    Enable = 1'b0;
    tick(1);
    check("disable S", int'(S), 0);
    check("disable Ready", int'(Ready), 0);

    // Dead time 5: each level-2 transition costs 5 cycles with both gates low.
    loadCompare(16'd600);
    startRun(16'd1000, 8'd5, "run dt5");
    waitSync("dt5 first");
    pushPer("c600 dt5", 498, 0, 498, 0, 194, 294, 0, 498);
    waitSync("dt5 cmp");

    // Band 3/4 = 0 -> sticky config error, no retry while Enable stays high.
    Enable = 1'b0;
    tick(1);
    PWMMaxCount = 16'd3;
    Enable = 1'b1;
    tick(25);
    check("cfgerr set", int'(CfgError), 1);
    check("cfgerr Ready", int'(Ready), 0);
    check("cfgerr S", int'(S), 0);
    tick(25);
    check("cfgerr sticky", int'(CfgError), 1);
    check("cfgerr no retry", int'(Ready), 0);
    Enable = 1'b0;
    tick(1);
    check("cfgerr cleared", int'(CfgError), 0);
    startRun(16'd1000, 8'd5, "rerun");
    check("rerun CfgError", int'(CfgError), 0);

    // Async reset while level 2 is inside a dead-time gap.
    waitSync("pre-reset");
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge MClk);
      if (S[5:4] == 2'b00) found = 1;
    end
    check("dead gap seen", int'(found), 1);
    #2 Rst = 1'b1;
    #1;
    check("async rst S", int'(S), 0);
    check("async rst Ready", int'(Ready), 0);
    Enable = 1'b0;
    @(negedge MClk);
    Rst = 1'b0;
    loadCompare(16'd600);
    startRun(16'd1000, 8'd5, "relaunch");
    waitSync("relaunch first");
    pushPer("relaunch dt5", 498, 0, 498, 0, 194, 294, 0, 498);
    waitSync("relaunch cmp");

    tick(2);
    check("never both high", bothHigh, 0);
    check("ready queue drained", readyQ.size(), 0);
    check("period queue drained", perQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
